// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl
// Drives the PC register's inputs. It selects the next PC, produces the hold
// signal and the IF/ID flush, and runs the fetch-control FSM that handles
// free run, debug single-step and HALT. It also keeps a saturating count of
// the cycles in which the PC advanced.
// All state updates happen on the falling edge of i_clk, the same edge the
// PC register samples on.
//
// Ports:
//   i_clk            clock (state updates on falling edge)
//   i_rst            asynchronous active-low reset
//   i_pc             current PC value
//   i_branch_taken   taken branch resolved this cycle
//   i_branch_target  branch target address
//   i_jump           jump decoded this cycle
//   i_jump_target    jump target address
//   i_hazard_stall   load-use stall request
//   i_halt_instr     fetched instruction is HALT
//   i_debug_mode     1 = single-step mode, 0 = free run
//   i_step           step request from the debug unit
//   o_next_pc        value to load into the PC
//   o_pc_enable      1 = hold PC, 0 = load o_next_pc
//   o_flush_if       squash the IF/ID instruction
//   o_halted         processor halted (registered)
//   o_cycle_count    number of cycles the PC advanced (saturating)
module pc_next_ctrl #(
    parameter int LEN     = 32,
    parameter int CNT_LEN = 32,
    parameter int PC_INC  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [LEN-1:0]     i_pc,
    input  logic               i_branch_taken,
    input  logic [LEN-1:0]     i_branch_target,
    input  logic               i_jump,
    input  logic [LEN-1:0]     i_jump_target,
    input  logic               i_hazard_stall,
    input  logic               i_halt_instr,
    input  logic               i_debug_mode,
    input  logic               i_step,
    output logic [LEN-1:0]     o_next_pc,
    output logic               o_pc_enable,
    output logic               o_flush_if,
    output logic               o_halted,
    output logic [CNT_LEN-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STEP_WAIT = 2'd1,
        STEP_EXEC = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [LEN-1:0]     PC_INC_W  = LEN'(PC_INC);
    localparam logic [CNT_LEN-1:0] CNT_MAX   = {CNT_LEN{1'b1}};
    localparam logic [CNT_LEN-1:0] CNT_ONE   = CNT_LEN'(1);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_LEN-1:0] count_reg;
    logic               redirect;
    logic               advance;
    logic               halt_take;

    // Branch resolves in an older instruction than the jump, so it wins.
    always_comb begin
        if (i_branch_taken) begin
            o_next_pc = i_branch_target;
        end else if (i_jump) begin
            o_next_pc = i_jump_target;
        end else begin
            o_next_pc = i_pc + PC_INC_W;   // wraps modulo 2^LEN
        end
    end

    assign redirect = i_branch_taken | i_jump;

    // A redirect overrides a hazard stall: the branch/jump comes from the
    // older instruction, so the stalled younger one is being squashed anyway.
    always_comb begin
        advance = 1'b0;
        if ((state_reg == RUN) || (state_reg == STEP_EXEC)) begin
            advance = !i_hazard_stall | redirect;
        end
    end

    // A HALT fetched on a wrong path (coinciding with a redirect) is ignored.
    assign halt_take = advance & i_halt_instr & !redirect;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            RUN: begin
                if (halt_take) begin
                    state_next = HALTED;
                end else if (i_debug_mode) begin
                    state_next = STEP_WAIT;
                end
            end
            STEP_WAIT: begin
                if (!i_debug_mode) begin
                    state_next = RUN;
                end else if (i_step) begin
                    state_next = STEP_EXEC;
                end
            end
            STEP_EXEC: begin
                // A stalled step stays here so it is not lost.
                if (halt_take) begin
                    state_next = HALTED;
                end else if (advance) begin
                    state_next = STEP_WAIT;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(negedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg <= RUN;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (advance && (count_reg != CNT_MAX)) begin
                count_reg <= count_reg + CNT_ONE;
            end
        end
    end

    assign o_pc_enable   = !advance;
    assign o_flush_if    = redirect & advance;
    assign o_halted      = (state_reg == HALTED);
    assign o_cycle_count = count_reg;

endmodule
